// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the cache-to-RAM memory controller: bus widths,
// load/store encoding, FSM states and the IO region default.
package mem_ctrl_pkg;

  typedef logic [31:0] addr_bus_t;
  typedef logic [31:0] data_bus_t;
  typedef logic [2:0]  len_bus_t;

  localparam logic LS_LOAD  = 1'b0;
  localparam logic LS_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    FETCH = 2'd3
  } state_t;

  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;
  localparam len_bus_t   FETCH_LEN     = 3'd4;

  // Bit offset of byte lane 0..3 inside a 32-bit little-endian word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises dcache loads/stores and icache fetches onto a byte-wide RAM/IO bus,
// assembling little-endian words and pulsing done to the requester.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iDC_en,
  input  logic        iDC_ls,
  input  logic [31:0] iDC_pc,
  input  logic [31:0] iDC_dt,
  input  logic [2:0]  iDC_len,
  output logic        oDC_done,
  output logic [31:0] oDC_dt,
  input  logic        iIC_en,
  input  logic [31:0] iIC_pc,
  output logic        oIC_done,
  output logic [31:0] oIC_dt,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t    state, state_nxt;

  logic      dc_pend;
  logic      dc_ls;
  addr_bus_t dc_pc;
  data_bus_t dc_dt;
  len_bus_t  dc_len;

  addr_bus_t addr;
  data_bus_t data;
  len_bus_t  len;
  len_bus_t  cnt;
  data_bus_t rd_buf;
  data_bus_t rd_merged;

  logic       accept_dc;
  logic       accept_ic;
  logic       io_stall;
  logic       rd_phase;
  logic       rd_last;
  logic       wr_last;
  logic [1:0] rd_lane;
  addr_bus_t  addr_off;

  assign io_stall = (addr[17:16] == IO_HI) && io_buffer_full;
  assign rd_phase = (state == LOAD) || (state == FETCH);
  assign rd_last  = (cnt == len);
  assign wr_last  = (cnt == len - 3'd1);
  // Byte arriving now belongs to the address driven one cycle earlier (cnt-1).
  assign rd_lane  = cnt[1:0] - 2'd1;

  // While frozen mid-read, re-present the previous address so mem_din still
  // carries the byte that is owed once rdy returns.
  assign addr_off = (rd_phase && !rdy && cnt != 3'd0) ? 32'(cnt) - 32'd1 : 32'(cnt);

  always_comb begin
    rd_merged = rd_buf;
    rd_merged[lane_lsb(rd_lane) +: 8] = mem_din;
  end

  always_comb begin
    state_nxt = state;
    accept_dc = 1'b0;
    accept_ic = 1'b0;
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (dc_pend) begin
          accept_dc = 1'b1;
          state_nxt = (dc_ls == LS_STORE) ? STORE : LOAD;
        end else if (iIC_en) begin
          accept_ic = 1'b1;
          state_nxt = FETCH;
        end
      end
      STORE: begin
        mem_a    = addr + addr_off;
        mem_dout = data[lane_lsb(cnt[1:0]) +: 8];
        mem_wr   = !io_stall;
        if (!io_stall && wr_last) state_nxt = IDLE;
      end
      LOAD, FETCH: begin
        mem_a = addr + addr_off;
        if (rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rdy) mem_wr = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dc_pend  <= 1'b0;
      dc_ls    <= 1'b0;
      dc_pc    <= '0;
      dc_dt    <= '0;
      dc_len   <= '0;
      addr     <= '0;
      data     <= '0;
      len      <= '0;
      cnt      <= '0;
      rd_buf   <= '0;
      oDC_done <= 1'b0;
      oDC_dt   <= '0;
      oIC_done <= 1'b0;
      oIC_dt   <= '0;
    end else if (rdy) begin
      state    <= state_nxt;
      oDC_done <= 1'b0;
      oIC_done <= 1'b0;

      if (accept_dc) begin
        addr    <= dc_pc;
        len     <= dc_len;
        data    <= dc_dt;
        cnt     <= '0;
        rd_buf  <= '0;
        dc_pend <= 1'b0;
      end

      if (accept_ic) begin
        addr   <= iIC_pc;
        len    <= FETCH_LEN;
        data   <= '0;
        cnt    <= '0;
        rd_buf <= '0;
      end

      if (state == STORE && !io_stall) begin
        cnt <= cnt + 3'd1;
        if (wr_last) oDC_done <= 1'b1;
      end

      if (rd_phase) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) rd_buf <= rd_merged;
        if (rd_last) begin
          if (state == FETCH) begin
            oIC_done <= 1'b1;
            oIC_dt   <= rd_merged;
          end else begin
            oDC_done <= 1'b1;
            oDC_dt   <= rd_merged;
          end
        end
      end

      // A pulse is captured in any state; it waits for the next IDLE.
      if (iDC_en) begin
        dc_pend <= 1'b1;
        dc_ls   <= iDC_ls;
        dc_pc   <= iDC_pc;
        dc_dt   <= iDC_dt;
        dc_len  <= iDC_len;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM bus model, event monitor and a
// word-level reference memory used to predict data, addresses and done timing.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        iDC_en, iDC_ls;
  logic [31:0] iDC_pc, iDC_dt;
  logic [2:0]  iDC_len;
  logic        oDC_done;
  logic [31:0] oDC_dt;
  logic        iIC_en;
  logic [31:0] iIC_pc;
  logic        oIC_done;
  logic [31:0] oIC_dt;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iDC_en(iDC_en), .iDC_ls(iDC_ls), .iDC_pc(iDC_pc), .iDC_dt(iDC_dt), .iDC_len(iDC_len),
    .oDC_done(oDC_done), .oDC_dt(oDC_dt),
    .iIC_en(iIC_en), .iIC_pc(iIC_pc), .oIC_done(oIC_done), .oIC_dt(oIC_dt),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int both_hi = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] dt; } ev_t;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_t;
  ev_t dc_q[$];
  ev_t ic_q[$];
  wr_t wr_q[$];

  logic [7:0] ram   [int unsigned];
  logic [7:0] model [int unsigned];
  logic [31:0] rd_a = 32'h0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < n; i++)
      w = w | (32'(model.exists(a + 32'(i)) ? model[a + 32'(i)] : dflt(a + 32'(i))) << (8 * i));
    return w;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) model[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]   = d;
    model[a] = d;
  endtask

  // RAM bus model: writes land mid-cycle, reads return one cycle later.
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_q.push_back('{cyc, mem_a, mem_dout});
      ram[mem_a] = mem_dout;
    end
    rd_a = mem_a;
    if (oDC_done) dc_q.push_back('{cyc, oDC_dt});
    if (oIC_done) ic_q.push_back('{cyc, oIC_dt});
    if (oDC_done && oIC_done) both_hi++;
    if (!rst && rdy)
      assert (!(iDC_en && dut.dc_pend)) else $error("illegal second dcache pulse at cycle %0d", cyc);
  end

  always @(posedge clk) begin
    #1 mem_din = ram_rd(rd_a);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (oIC_done) iIC_en = 1'b0;
  endtask

  task automatic dc_pulse(input logic ls, input logic [31:0] pc, input logic [31:0] dt,
                          input logic [2:0] len, output int pcyc);
    iDC_en  = 1'b1;
    iDC_ls  = ls;
    iDC_pc  = pc;
    iDC_dt  = dt;
    iDC_len = len;
    pcyc    = cyc;
    tick();
    iDC_en  = 1'b0;
  endtask

  task automatic wait_ev(input bit ic, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = ic ? (ic_q.size() >= n) : (dc_q.size() >= n);
    end
  endtask

  task automatic settle();
    iIC_en = 1'b0;
    repeat (8) tick();
    dc_q.delete();
    ic_q.delete();
    wr_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({mem_wr, mem_a, mem_dout} !== 41'h0) begin
      bad++;
      $display("FAIL reset_bus: got wr=%b a=%h dout=%h want all 0", mem_wr, mem_a, mem_dout);
    end
    total++;
    if ({oDC_done, oDC_dt, oIC_done, oIC_dt} !== 66'h0) begin
      bad++;
      $display("FAIL reset_cache: got dcd=%b dcdt=%h icd=%b icdt=%h want all 0",
               oDC_done, oDC_dt, oIC_done, oIC_dt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_word();
    int p; bit ok;
    settle();
    dc_pulse(LS_STORE, 32'h100, 32'hAABBCCDD, 3'd4, p);
    model_store(32'h100, 32'hAABBCCDD, 4);
    wait_ev(1'b0, 1, 20, ok);
    total++;
    if (!ok || dc_q[0].cyc != p + 6) begin
      bad++;
      $display("FAIL store_done: got ok=%b cyc=%0d want cyc=%0d", ok, ok ? dc_q[0].cyc : -1, p + 6);
    end
    total++;
    if (wr_q.size() != 4) begin
      bad++;
      $display("FAIL store_count: got %0d writes want 4", wr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] w = 32'hAABBCCDD;
        total++;
        if (wr_q[i].a !== 32'h100 + 32'(i) || wr_q[i].d !== w[8*i +: 8] || wr_q[i].cyc != p + 2 + i) begin
          bad++;
          $display("FAIL store_byte%0d: got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d", i,
                   wr_q[i].a, wr_q[i].d, wr_q[i].cyc, 32'h100 + 32'(i), w[8*i +: 8], p + 2 + i);
        end
      end
    end
  endtask

  task automatic test_load_half();
    int p; bit ok;
    settle();
    preload(32'h200, 8'h34);
    preload(32'h201, 8'h12);
    dc_pulse(LS_LOAD, 32'h200, 32'hFFFF_FFFF, 3'd2, p);
    wait_ev(1'b0, 1, 20, ok);
    total++;
    if (!ok || dc_q[0].dt !== 32'h0000_1234 || dc_q[0].cyc != p + 5 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL load_half: got ok=%b dt=%h cyc=%0d writes=%0d want dt=00001234 cyc=%0d writes=0",
               ok, ok ? dc_q[0].dt : 32'h0, ok ? dc_q[0].cyc : -1, wr_q.size(), p + 5);
    end
  endtask

  task automatic test_io_stall();
    int p; bit ok;
    settle();
    io_buffer_full = 1'b1;
    dc_pulse(LS_STORE, 32'h0003_0000, 32'h0000_0041, 3'd1, p);
    model_store(32'h0003_0000, 32'h41, 1);
    repeat (4) tick();
    io_buffer_full = 1'b0;
    wait_ev(1'b0, 1, 20, ok);
    total++;
    if (wr_q.size() != 1 || wr_q[0].a !== 32'h0003_0000 || wr_q[0].d !== 8'h41 || wr_q[0].cyc != p + 5) begin
      bad++;
      $display("FAIL io_stall_write: got n=%0d first_cyc=%0d want n=1 a=00030000 d=41 cyc=%0d",
               wr_q.size(), wr_q.size() > 0 ? wr_q[0].cyc : -1, p + 5);
    end
    total++;
    if (!ok || dc_q[0].cyc != p + 6) begin
      bad++;
      $display("FAIL io_stall_done: got cyc=%0d want %0d", ok ? dc_q[0].cyc : -1, p + 6);
    end
    // Outside the IO region the full flag must not stall.
    settle();
    io_buffer_full = 1'b1;
    dc_pulse(LS_STORE, 32'h0002_0000, 32'h0000_5566, 3'd2, p);
    model_store(32'h0002_0000, 32'h5566, 2);
    wait_ev(1'b0, 1, 20, ok);
    io_buffer_full = 1'b0;
    total++;
    if (!ok || dc_q[0].cyc != p + 4 || wr_q.size() != 2 || wr_q[1].d !== 8'h55 || wr_q[1].cyc != p + 3) begin
      bad++;
      $display("FAIL non_io_no_stall: got done=%0d writes=%0d want done=%0d writes=2",
               ok ? dc_q[0].cyc : -1, wr_q.size(), p + 4);
    end
  endtask

  task automatic test_priority();
    int p, q; bit ok;
    logic [31:0] fw;
    settle();
    dc_pulse(LS_STORE, 32'h400, 32'h0BAD_F00D, 3'd4, p);
    model_store(32'h400, 32'h0BAD_F00D, 4);
    tick();
    tick();
    fw = model_word(32'h0, 4);
    iIC_en = 1'b1;
    iIC_pc = 32'h0;
    dc_pulse(LS_LOAD, 32'h200, 32'h0, 3'd2, q);
    wait_ev(1'b1, 1, 60, ok);
    iIC_en = 1'b0;
    total++;
    if (dc_q.size() != 2 || dc_q[0].cyc != p + 6 || dc_q[1].cyc != p + 10 || dc_q[1].dt !== 32'h1234) begin
      bad++;
      $display("FAIL prio_load_first: got n=%0d load_cyc=%0d load_dt=%h want n=2 cyc=%0d dt=00001234",
               dc_q.size(), dc_q.size() > 1 ? dc_q[1].cyc : -1, dc_q.size() > 1 ? dc_q[1].dt : 32'h0, p + 10);
    end
    total++;
    if (!ok || ic_q[0].cyc != p + 16 || ic_q[0].dt !== fw) begin
      bad++;
      $display("FAIL prio_fetch_after: got ok=%b cyc=%0d dt=%h want cyc=%0d dt=%h",
               ok, ok ? ic_q[0].cyc : -1, ok ? ic_q[0].dt : 32'h0, p + 16, fw);
    end
  endtask

  task automatic test_fetch_then_pulse();
    int c, p; bit ok;
    logic [31:0] fw, lw;
    settle();
    fw = model_word(32'h40, 4);
    lw = model_word(32'h80, 4);
    c = cyc;
    iIC_en = 1'b1;
    iIC_pc = 32'h40;
    dc_pulse(LS_LOAD, 32'h80, 32'h0, 3'd4, p);
    wait_ev(1'b0, 1, 40, ok);
    iIC_en = 1'b0;
    total++;
    if (ic_q.size() != 1 || ic_q[0].cyc != c + 6 || ic_q[0].dt !== fw) begin
      bad++;
      $display("FAIL fetch_first: got n=%0d cyc=%0d dt=%h want cyc=%0d dt=%h", ic_q.size(),
               ic_q.size() > 0 ? ic_q[0].cyc : -1, ic_q.size() > 0 ? ic_q[0].dt : 32'h0, c + 6, fw);
    end
    total++;
    if (!ok || dc_q[0].cyc != c + 12 || dc_q[0].dt !== lw) begin
      bad++;
      $display("FAIL pulse_after_fetch: got cyc=%0d dt=%h want cyc=%0d dt=%h",
               ok ? dc_q[0].cyc : -1, ok ? dc_q[0].dt : 32'h0, c + 12, lw);
    end
  endtask

  task automatic test_rdy_fetch();
    int c; bit ok;
    logic [31:0] fw;
    settle();
    preload(32'h1000, 8'h11);
    preload(32'h1001, 8'h22);
    preload(32'h1002, 8'h33);
    preload(32'h1003, 8'h44);
    fw = model_word(32'h1000, 4);
    c = cyc;
    iIC_en = 1'b1;
    iIC_pc = 32'h1000;
    repeat (3) tick();
    rdy = 1'b0;
    repeat (2) tick();
    rdy = 1'b1;
    wait_ev(1'b1, 1, 30, ok);
    iIC_en = 1'b0;
    total++;
    if (!ok || ic_q[0].cyc != c + 8 || ic_q[0].dt !== fw || wr_q.size() != 0) begin
      bad++;
      $display("FAIL rdy_fetch: got cyc=%0d dt=%h writes=%0d want cyc=%0d dt=%h writes=0",
               ok ? ic_q[0].cyc : -1, ok ? ic_q[0].dt : 32'h0, wr_q.size(), c + 8, fw);
    end
  endtask

  task automatic test_rst_load();
    int p; bit ok;
    logic [31:0] lw;
    settle();
    lw = model_word(32'h300, 4);
    dc_pulse(LS_LOAD, 32'h300, 32'h0, 3'd4, p);
    wait_ev(1'b0, 1, 20, ok);
    total++;
    if (!ok || dc_q[0].dt !== lw) begin
      bad++;
      $display("FAIL pre_rst_load: got dt=%h want %h", ok ? dc_q[0].dt : 32'h0, lw);
    end
    settle();
    dc_pulse(LS_LOAD, 32'h500, 32'h0, 3'd4, p);
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({mem_wr, mem_a, mem_dout, oDC_done, oDC_dt, oIC_done, oIC_dt} !== 107'h0) begin
      bad++;
      $display("FAIL rst_outputs: got a=%h dcdt=%h dcd=%b want all 0", mem_a, oDC_dt, oDC_done);
    end
    rst = 1'b0;
    repeat (12) tick();
    total++;
    if (dc_q.size() != 0 || ic_q.size() != 0) begin
      bad++;
      $display("FAIL rst_no_done: got dc=%0d ic=%0d done pulses want 0", dc_q.size(), ic_q.size());
    end
    settle();
    dc_pulse(LS_LOAD, 32'h200, 32'h0, 3'd2, p);
    wait_ev(1'b0, 1, 20, ok);
    total++;
    if (!ok || dc_q[0].dt !== 32'h1234 || dc_q[0].cyc != p + 5) begin
      bad++;
      $display("FAIL post_rst_load: got dt=%h cyc=%0d want dt=00001234 cyc=%0d",
               ok ? dc_q[0].dt : 32'h0, ok ? dc_q[0].cyc : -1, p + 5);
    end
  endtask

  task automatic test_wrap();
    int p; bit ok;
    logic [31:0] d;
    settle();
    d = $urandom();
    dc_pulse(LS_STORE, 32'hFFFF_FFFE, d, 3'd4, p);
    model_store(32'hFFFF_FFFE, d, 4);
    wait_ev(1'b0, 1, 20, ok);
    total++;
    if (wr_q.size() != 4 || wr_q[2].a !== 32'h0 || wr_q[3].a !== 32'h1 || wr_q[1].a !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_addr: got n=%0d a2=%h want n=4 a2=00000000", wr_q.size(),
               wr_q.size() > 2 ? wr_q[2].a : 32'hX);
    end
    settle();
    dc_pulse(LS_LOAD, 32'hFFFF_FFFE, 32'h0, 3'd4, p);
    wait_ev(1'b0, 1, 20, ok);
    total++;
    if (!ok || dc_q[0].dt !== d) begin
      bad++;
      $display("FAIL wrap_load: got %h want %h", ok ? dc_q[0].dt : 32'h0, d);
    end
  endtask

  task automatic test_random();
    int p, n; bit ok;
    logic ls;
    logic [2:0] len;
    logic [31:0] pc, dt, exp_dt;
    settle();
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) tick();
      dc_q.delete();
      wr_q.delete();
      ls  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       len = 3'd1;
        1:       len = 3'd2;
        default: len = 3'd4;
      endcase
      n   = int'(len);
      pc  = ($urandom_range(0, 1) == 1) ? 32'h8000 + 32'($urandom_range(0, 15)) : $urandom();
      dt  = $urandom();
      exp_dt = model_word(pc, n);
      dc_pulse(ls, pc, dt, len, p);
      if (ls == LS_STORE) model_store(pc, dt, n);
      wait_ev(1'b0, 1, 20, ok);
      total++;
      if (ls == LS_STORE) begin
        if (!ok || dc_q[0].cyc != p + n + 2 || wr_q.size() != n) begin
          bad++;
          $display("FAIL rnd_store%0d: got done=%0d writes=%0d want done=%0d writes=%0d", it,
                   ok ? dc_q[0].cyc : -1, wr_q.size(), p + n + 2, n);
        end else begin
          for (int i = 0; i < n; i++) begin
            total++;
            if (wr_q[i].a !== pc + 32'(i) || wr_q[i].d !== dt[8*i +: 8] || wr_q[i].cyc != p + 2 + i) begin
              bad++;
              $display("FAIL rnd_store%0d_b%0d: got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d", it, i,
                       wr_q[i].a, wr_q[i].d, wr_q[i].cyc, pc + 32'(i), dt[8*i +: 8], p + 2 + i);
            end
          end
        end
      end else begin
        if (!ok || dc_q[0].cyc != p + n + 3 || dc_q[0].dt !== exp_dt || wr_q.size() != 0) begin
          bad++;
          $display("FAIL rnd_load%0d: got done=%0d dt=%h want done=%0d dt=%h", it,
                   ok ? dc_q[0].cyc : -1, ok ? dc_q[0].dt : 32'h0, p + n + 3, exp_dt);
        end
      end
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (both_hi != 0) begin
      bad++;
      $display("FAIL done_exclusive: got %0d cycles with both done high want 0", both_hi);
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    iDC_en = 1'b0;
    iDC_ls = 1'b0;
    iDC_pc = 32'h0;
    iDC_dt = 32'h0;
    iDC_len = 3'd0;
    iIC_en = 1'b0;
    iIC_pc = 32'h0;
    io_buffer_full = 1'b0;
    test_reset();
    test_store_word();
    test_load_half();
    test_io_stall();
    test_priority();
    test_fetch_then_pulse();
    test_rdy_fetch();
    test_rst_load();
    test_wrap();
    test_random();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
